beam_trig_scaler: RTL and testbench



---
 rtl/beam_trig_scaler.sv | 232 +++++++++++++++++++++++
 tb/tb_beam_trig_scaler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_trig_scaler.sv
// -----------------------------------------------------------------------------
// beam_trig_scaler
//
// Per-beam trigger rate scaler. Counts the trigger bits of every beam over a
// fixed gate of PERIOD enabled clocks. At the end of each gate it snapshots all
// counts into a holding bank. It then streams the bank out as one 32-bit word
// per beam, framed with m_tlast on the final beam.
//
// Parameters
//   NBEAMS     number of beams (1..16384)
//   CNT_WIDTH  per-beam counter width (1..16), saturating
//   PERIOD     gate length in clocks (>= NBEAMS+2)
//
// Ports
//   aclk          clock, rising edge
//   arst          asynchronous active-high reset
//   trig_i        per-beam trigger bits, bit b is beam b
//   enable_i      gate enable; when low the timer and counters are held at 0
//   m_tdata       {sat, drop, beam index[13:0], count[15:0]}
//   m_tvalid      output word valid
//   m_tready      downstream ready
//   m_tlast       final beam word of a frame
//   drop_count_o  saturating count of snapshots dropped because readout was busy
// -----------------------------------------------------------------------------
module beam_trig_scaler #(
    parameter int NBEAMS    = 2,
    parameter int CNT_WIDTH = 16,
    parameter int PERIOD    = 1000
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic [NBEAMS-1:0] trig_i,
    input  logic              enable_i,
    output logic [31:0]       m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [7:0]        drop_count_o
);

    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int IW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;

    localparam logic [TW-1:0]        TIMER_LAST = TW'(PERIOD - 1);
    localparam logic [IW-1:0]        IDX_LAST   = IW'(NBEAMS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // -------------------------------------------------------------------------
    // Gate timer
    // -------------------------------------------------------------------------
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          tick;

    assign tick = enable_i && (timer_q == TIMER_LAST);

    always_comb begin
        timer_d = timer_q;
        if (!enable_i) begin
            timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // -------------------------------------------------------------------------
    // Readout FSM state (declared early: the snapshot strobe depends on it)
    // -------------------------------------------------------------------------
    logic [0:0]    state_q;
    logic [0:0]    state_d;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic          pend_drop_q;
    logic          pend_drop_d;
    logic          hold_drop_q;
    logic          hold_drop_d;
    logic [7:0]    drop_cnt_q;
    logic [7:0]    drop_cnt_d;

    // A tick is only taken while idle; a tick landing on the cycle of the last
    // handshake still sees SEND and is therefore dropped.
    logic snap_take;
    assign snap_take = tick && (state_q == ST_IDLE);

    // -------------------------------------------------------------------------
    // Beam counters and holding bank
    // -------------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] cnt_q    [NBEAMS];
    logic [CNT_WIDTH-1:0] cnt_inc  [NBEAMS];
    logic [NBEAMS-1:0]    sat_q;
    logic [NBEAMS-1:0]    sat_inc;

    logic [CNT_WIDTH-1:0] hold_cnt_q [NBEAMS];
    logic [NBEAMS-1:0]    hold_sat_q;

    generate
        for (genvar gi = 0; gi < NBEAMS; gi++) begin : g_beam
            // cnt_inc already contains this cycle's trigger, so the snapshot on
            // the tick cycle includes the trigger seen on that cycle.
            assign cnt_inc[gi] = (trig_i[gi] && (cnt_q[gi] != CNT_MAX))
                               ? cnt_q[gi] + CNT_WIDTH'(1)
                               : cnt_q[gi];
            assign sat_inc[gi] = sat_q[gi] | (cnt_inc[gi] == CNT_MAX);

            always_ff @(posedge aclk or posedge arst) begin
                if (arst) begin
                    cnt_q[gi] <= '0;
                    sat_q[gi] <= 1'b0;
                end else if (!enable_i || tick) begin
                    // Held at zero while disabled; restarted on every gate edge
                    // whether or not the snapshot was taken.
                    cnt_q[gi] <= '0;
                    sat_q[gi] <= 1'b0;
                end else begin
                    cnt_q[gi] <= cnt_inc[gi];
                    sat_q[gi] <= sat_inc[gi];
                end
            end

            // Holding bank needs no reset: it is only visible while in SEND,
            // and SEND is only entered after a snapshot has been written.
            always_ff @(posedge aclk) begin
                if (snap_take) begin
                    hold_cnt_q[gi] <= cnt_inc[gi];
                    hold_sat_q[gi] <= sat_inc[gi];
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Readout mux
    // -------------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] rd_cnt;
    logic                 rd_sat;

    generate
        if (NBEAMS == 1) begin : g_rd_single
            assign rd_cnt = hold_cnt_q[0];
            assign rd_sat = hold_sat_q[0];
        end else begin : g_rd_multi
            assign rd_cnt = hold_cnt_q[idx_q];
            assign rd_sat = hold_sat_q[idx_q];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // FSM next state, drop tracking
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pend_drop_d = pend_drop_q;
        hold_drop_d = hold_drop_q;
        drop_cnt_d  = drop_cnt_q;

        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (tick) begin
                    state_d     = ST_SEND;
                    hold_drop_d = pend_drop_q;
                    pend_drop_d = 1'b0;
                end
            end
            ST_SEND: begin
                if (m_tready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                if (tick) begin
                    pend_drop_d = 1'b1;
                    if (drop_cnt_q != 8'hFF) begin
                        drop_cnt_d = drop_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            pend_drop_q <= 1'b0;
            hold_drop_q <= 1'b0;
            drop_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_drop_q <= pend_drop_d;
            hold_drop_q <= hold_drop_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all driven from registers, forced to zero outside SEND so the
    // reset values appear as soon as arst clears the state register.
    // -------------------------------------------------------------------------
    logic send_active;
    assign send_active = (state_q == ST_SEND);

    assign m_tvalid     = send_active;
    assign m_tlast      = send_active && (idx_q == IDX_LAST);
    assign m_tdata      = send_active
                        ? {rd_sat, hold_drop_q, 14'(idx_q), 16'(rd_cnt)}
                        : 32'd0;
    assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_beam_trig_scaler.sv
// -----------------------------------------------------------------------------
// tb_beam_trig_scaler
//
// Drives two instances (CNT_WIDTH 16 and 4, NBEAMS=2, PERIOD=16) with the same
// stimulus. A reference model in the stimulus process accumulates raw trigger
// sums per gate and pushes the expected frame words into one scoreboard queue
// per instance. A monitor on the falling edge pops and compares on handshakes.
// -----------------------------------------------------------------------------
module tb_beam_trig_scaler;

    localparam int NB  = 2;
    localparam int PER = 16;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic            aclk = 1'b0;
    logic            arst;
    logic            enable;
    logic [NB-1:0]   trig;
    logic            ready;

    logic [1:0][31:0] tdata;
    logic [1:0]       tvalid;
    logic [1:0]       tlast;
    logic [1:0][7:0]  dcount;

    always #5 aclk = ~aclk;

    beam_trig_scaler #(.NBEAMS(NB), .CNT_WIDTH(16), .PERIOD(PER)) dut16 (
        .aclk(aclk), .arst(arst), .trig_i(trig), .enable_i(enable),
        .m_tdata(tdata[0]), .m_tvalid(tvalid[0]), .m_tready(ready),
        .m_tlast(tlast[0]), .drop_count_o(dcount[0])
    );

    beam_trig_scaler #(.NBEAMS(NB), .CNT_WIDTH(4), .PERIOD(PER)) dut4 (
        .aclk(aclk), .arst(arst), .trig_i(trig), .enable_i(enable),
        .m_tdata(tdata[1]), .m_tvalid(tvalid[1]), .m_tready(ready),
        .m_tlast(tlast[1]), .drop_count_o(dcount[1])
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model state ----------------
    exp_t        sb0[$];
    exp_t        sb1[$];
    int unsigned sums [NB];
    int          gate_pos;
    int          words_left [2];
    int          drops [2];
    bit          pend [2];
    bit          exp_valid [2];
    int          exp_dc [2];
    int unsigned cnt_max [2] = '{65535, 15};

    function automatic void q_push(int d, exp_t e);
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endfunction

    function automatic int q_size(int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic exp_t q_pop(int d);
        exp_t e;
        if (d == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        return e;
    endfunction

    task automatic reset_model();
        sb0.delete();
        sb1.delete();
        gate_pos = 0;
        for (int b = 0; b < NB; b++) sums[b] = 0;
        for (int d = 0; d < 2; d++) begin
            words_left[d] = 0;
            drops[d]      = 0;
            pend[d]       = 1'b0;
            exp_valid[d]  = 1'b0;
            exp_dc[d]     = 0;
        end
    endtask

    // One clock edge of behaviour: gate bookkeeping, snapshot or drop, readout.
    task automatic model_step();
        bit   gate_end;
        bit   busy;
        exp_t e;
        int unsigned c;
        gate_end = enable && (gate_pos == PER - 1);
        if (enable) begin
            for (int b = 0; b < NB; b++) sums[b] += trig[b];
        end
        for (int d = 0; d < 2; d++) begin
            busy = (words_left[d] > 0);
            if (busy && ready) words_left[d]--;
            if (gate_end) begin
                if (busy) begin
                    if (drops[d] < 255) drops[d]++;
                    pend[d] = 1'b1;
                end else begin
                    for (int b = 0; b < NB; b++) begin
                        c = (sums[b] > cnt_max[d]) ? cnt_max[d] : sums[b];
                        e.data = {(sums[b] >= cnt_max[d]), pend[d], 14'(b), 16'(c)};
                        e.last = (b == NB - 1);
                        q_push(d, e);
                    end
                    pend[d]       = 1'b0;
                    words_left[d] = NB;
                end
            end
            exp_valid[d] = (words_left[d] > 0);
            exp_dc[d]    = drops[d];
        end
        if (gate_end || !enable) begin
            for (int b = 0; b < NB; b++) sums[b] = 0;
        end
        gate_pos = !enable ? 0 : ((gate_pos == PER - 1) ? 0 : gate_pos + 1);
    endtask

    task automatic drive(input bit en, input logic [NB-1:0] tr, input bit rd, input bit rs);
        arst   = rs;
        enable = en;
        trig   = tr;
        ready  = rd;
        if (rs) reset_model();
        @(posedge aclk);
        if (arst) reset_model();
        else      model_step();
        #1;
    endtask

    // ---------------- monitor ----------------
    bit          stall [2];
    logic [31:0] prev_data [2];
    logic        prev_last [2];

    initial begin
        exp_t e;
        for (int d = 0; d < 2; d++) stall[d] = 1'b0;
        forever begin
            @(negedge aclk);
            for (int d = 0; d < 2; d++) begin
                if (arst) begin
                    checks++;
                    if (tvalid[d] !== 1'b0 || tdata[d] !== 32'd0 || tlast[d] !== 1'b0 || dcount[d] !== 8'd0) begin
                        errors++;
                        $display("FAIL reset_outputs dut%0d t=%0t got valid=%b data=%h last=%b drops=%0d need all zero",
                                 d, $time, tvalid[d], tdata[d], tlast[d], dcount[d]);
                    end
                    stall[d] = 1'b0;
                end else begin
                    checks++;
                    if (tvalid[d] !== exp_valid[d]) begin
                        errors++;
                        $display("FAIL tvalid dut%0d t=%0t got %b need %b", d, $time, tvalid[d], exp_valid[d]);
                    end
                    checks++;
                    if (dcount[d] !== 8'(exp_dc[d])) begin
                        errors++;
                        $display("FAIL drop_count dut%0d t=%0t got %0d need %0d", d, $time, dcount[d], exp_dc[d]);
                    end
                    if (stall[d]) begin
                        checks++;
                        if (tdata[d] !== prev_data[d] || tlast[d] !== prev_last[d]) begin
                            errors++;
                            $display("FAIL hold_stable dut%0d t=%0t got %h/%b need %h/%b",
                                     d, $time, tdata[d], tlast[d], prev_data[d], prev_last[d]);
                        end
                    end
                    if (tvalid[d] === 1'b1 && ready === 1'b1) begin
                        checks++;
                        if (q_size(d) == 0) begin
                            errors++;
                            $display("FAIL unexpected_word dut%0d t=%0t got %h last=%b need no word",
                                     d, $time, tdata[d], tlast[d]);
                        end else begin
                            e = q_pop(d);
                            if (tdata[d] !== e.data || tlast[d] !== e.last) begin
                                errors++;
                                $display("FAIL word dut%0d t=%0t got %h last=%b need %h last=%b",
                                         d, $time, tdata[d], tlast[d], e.data, e.last);
                            end else begin
                                $display("dut%0d t=%0t word %h last=%b", d, $time, tdata[d], tlast[d]);
                            end
                        end
                    end
                    stall[d]     = (tvalid[d] === 1'b1) && (ready === 1'b0);
                    prev_data[d] = tdata[d];
                    prev_last[d] = tlast[d];
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int bp;
        int hold_cycles;
        bit rd;
        arst   = 1'b1;
        enable = 1'b1;
        trig   = 2'b11;
        ready  = 1'b1;
        reset_model();

        // Reset held for 3 cycles with triggers active
        for (int i = 0; i < 3; i++) drive(1'b1, 2'b11, 1'b1, 1'b1);

        // Basic frames
        for (int i = 0; i < 40; i++) drive(1'b1, 2'b01, 1'b1, 1'b0);

        // Backpressure: 5 stalled cycles at the start of each frame
        bp = 0;
        for (int i = 0; i < 60; i++) begin
            if (words_left[0] == 0) bp = 0;
            rd = !((words_left[0] > 0) && (bp < 5));
            if (!rd) bp++;
            drive(1'b1, 2'b01, rd, 1'b0);
        end

        // Drop: long stall spanning several gates, then release
        for (int i = 0; i < 40; i++) drive(1'b1, 2'b10, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) drive(1'b1, 2'b10, 1'b1, 1'b0);

        // Saturation: one aligned gate of 2'b11, then quiet gates
        drive(1'b1, 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < PER; i++) drive(1'b1, 2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 2 * PER; i++) drive(1'b1, 2'b00, 1'b1, 1'b0);

        // Enable gating mid-gate
        for (int i = 0; i < 5; i++)  drive(1'b1, 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)  drive(1'b0, 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) drive(1'b1, 2'b01, 1'b1, 1'b0);

        // Randomized traffic with occasional long stalls and rare resets
        hold_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_cycles > 0) begin
                hold_cycles--;
                rd = 1'b0;
            end else if ($urandom_range(0, 99) == 0) begin
                hold_cycles = $urandom_range(10, 40);
                rd = 1'b0;
            end else begin
                rd = ($urandom_range(0, 3) != 0);
            end
            drive(($urandom_range(0, 15) != 0), 2'($urandom_range(0, 3)), rd,
                  ($urandom_range(0, 499) == 0));
        end

        // Drain
        for (int i = 0; i < 10; i++) drive(1'b0, 2'b00, 1'b1, 1'b0);
        @(negedge aclk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (q_size(d) != 0) begin
                errors++;
                $display("FAIL drain dut%0d got %0d words outstanding need 0", d, q_size(d));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
